// File: rtl/alu_issue_writeback.sv
// rtl/alu_issue_writeback.sv - issue, EX register and buffered writeback around the 32-bit ALU
module alu_issue_writeback #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_ra,
  input  logic [AW-1:0] instr_rb,
  input  logic [4:0]    instr_shamt,
  input  logic [31:0]   instr_imm,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic          alu_c_0,
  output logic          alu_const_var,
  output logic          alu_shift_direction,
  output logic [1:0]    alu_function_class,
  output logic [1:0]    alu_logic_function,
  output logic [4:0]    alu_const_amount,
  input  logic [31:0]   alu_s,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_rd,
  output logic [31:0]   wb_data,
  output logic          err_illegal,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  logic [31:0]   rf_q [NREGS];

  // EX register; the alu_* outputs are driven straight from it so they hold while idle
  logic          ex_valid_q, ex_valid_d;
  logic          ex_ldi_q;
  logic [AW-1:0] ex_rd_q;
  logic [31:0]   ex_imm_q;
  logic [31:0]   alu_a_q, alu_b_q;
  logic          alu_c_0_q, alu_cv_q, alu_dir_q;
  logic [1:0]    alu_class_q, alu_lf_q;
  logic [4:0]    alu_amt_q;

  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q, err_d;

  logic          dec_legal, dec_ldi, dec_c0, dec_cv, dec_dir;
  logic [1:0]    dec_class, dec_lf;
  logic [31:0]   ex_result, opa, opb;
  logic          ex_retire, accept, fwd_en;

  assign ex_result   = ex_ldi_q ? ex_imm_q : alu_s;
  assign ex_retire   = ex_valid_q && (!wb_valid_q || wb_ready);
  assign instr_ready = !ex_valid_q || ex_retire;
  assign accept      = instr_valid && instr_ready;

  // The retiring result is written on the same edge this read is captured, so bypass it
  assign fwd_en = ex_retire && (ex_rd_q != '0);
  assign opa    = (fwd_en && (instr_ra == ex_rd_q)) ? ex_result : rf_q[instr_ra];
  assign opb    = (fwd_en && (instr_rb == ex_rd_q)) ? ex_result : rf_q[instr_rb];

  // Opcode decode into ALU control fields; unused fields stay 0
  always_comb begin
    dec_legal = 1'b1;
    dec_ldi   = 1'b0;
    dec_class = 2'b00;
    dec_lf    = 2'b00;
    dec_c0    = 1'b0;
    dec_cv    = 1'b0;
    dec_dir   = 1'b0;
    case (instr_op)
      4'd0:  dec_class = 2'b10;
      4'd1:  begin dec_class = 2'b10; dec_c0 = 1'b1; end
      4'd2:  begin dec_class = 2'b01; dec_c0 = 1'b1; end
      4'd3:  begin dec_class = 2'b11; dec_lf = 2'b00; end
      4'd4:  begin dec_class = 2'b11; dec_lf = 2'b01; end
      4'd5:  begin dec_class = 2'b11; dec_lf = 2'b10; end
      4'd6:  begin dec_class = 2'b11; dec_lf = 2'b11; end
      4'd7:  dec_dir = 1'b1;
      4'd8:  dec_dir = 1'b0;
      4'd9:  begin dec_cv = 1'b1; dec_dir = 1'b1; end
      4'd10: dec_cv = 1'b1;
      4'd11: dec_ldi = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state for EX occupancy, writeback buffer and the sticky error flag
  always_comb begin
    ex_valid_d = ex_valid_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    if (ex_retire) begin
      ex_valid_d = 1'b0;
    end
    if (accept) begin
      if (dec_legal) begin
        ex_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (ex_retire) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ex_rd_q;
      wb_data_d  = ex_result;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  // EX register: loads only on a legal accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ldi_q    <= 1'b0;
      ex_rd_q     <= '0;
      ex_imm_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_0_q   <= 1'b0;
      alu_cv_q    <= 1'b0;
      alu_dir_q   <= 1'b0;
      alu_class_q <= 2'b00;
      alu_lf_q    <= 2'b00;
      alu_amt_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept && dec_legal) begin
        ex_ldi_q    <= dec_ldi;
        ex_rd_q     <= instr_rd;
        ex_imm_q    <= instr_imm;
        alu_a_q     <= opa;
        alu_b_q     <= opb;
        alu_c_0_q   <= dec_c0;
        alu_cv_q    <= dec_cv;
        alu_dir_q   <= dec_dir;
        alu_class_q <= dec_class;
        alu_lf_q    <= dec_lf;
        alu_amt_q   <= instr_shamt;
      end
    end
  end

  // Writeback buffer and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  // Register file; entry 0 is never written so it always reads 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (ex_retire && (ex_rd_q != '0)) begin
      rf_q[ex_rd_q] <= ex_result;
    end
  end

  assign alu_a               = alu_a_q;
  assign alu_b               = alu_b_q;
  assign alu_c_0             = alu_c_0_q;
  assign alu_const_var       = alu_cv_q;
  assign alu_shift_direction = alu_dir_q;
  assign alu_function_class  = alu_class_q;
  assign alu_logic_function  = alu_lf_q;
  assign alu_const_amount    = alu_amt_q;
  assign wb_valid            = wb_valid_q;
  assign wb_rd               = wb_rd_q;
  assign wb_data             = wb_data_q;
  assign err_illegal         = err_q;
  assign dbg_data            = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_writeback.sv
// tb/tb_alu_issue_writeback.sv - scoreboard bench for alu_issue_writeback with a behavioural ALU
module tb_alu_issue_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic [4:0]  instr_shamt;
  logic [31:0] instr_imm;
  logic [31:0] alu_a, alu_b, alu_s;
  logic        alu_c_0, alu_const_var, alu_shift_direction;
  logic [1:0]  alu_function_class, alu_logic_function;
  logic [4:0]  alu_const_amount;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [34:0] exp_q[$];
  int pop_cyc[$];

  alu_issue_writeback #(.NREGS(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_shamt(instr_shamt), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_0(alu_c_0), .alu_const_var(alu_const_var),
    .alu_shift_direction(alu_shift_direction), .alu_function_class(alu_function_class),
    .alu_logic_function(alu_logic_function), .alu_const_amount(alu_const_amount),
    .alu_s(alu_s), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the external combinational ALU
  always_comb begin
    logic [4:0]  amt;
    logic [31:0] diff;
    alu_s = 32'd0;
    amt   = alu_const_var ? alu_a[4:0] : alu_const_amount;
    diff  = alu_a - alu_b;
    case (alu_function_class)
      2'b00: alu_s = alu_shift_direction ? (alu_b << amt) : (alu_b >> amt);
      2'b01: alu_s = {31'd0, diff[31]};
      2'b10: alu_s = alu_c_0 ? diff : (alu_a + alu_b);
      default: case (alu_logic_function)
        2'b00: alu_s = alu_a & alu_b;
        2'b01: alu_s = alu_a | alu_b;
        2'b10: alu_s = alu_a ^ alu_b;
        default: alu_s = ~(alu_a | alu_b);
      endcase
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every writeback handshake is compared against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("wb_rd", {29'd0, wb_rd}, {29'd0, e[34:32]});
          check("wb_data", wb_data, e[31:0]);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    #1;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [4:0] sh, input logic [31:0] imm,
                       input bit push, input logic [31:0] exp);
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_shamt = sh; instr_imm = imm; instr_valid = 1'b1;
    if (push) exp_q.push_back({rd, exp});
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((exp_q.size() != 0 || wb_valid) && n < 100);
    check("drain_timeout", {31'd0, (exp_q.size() != 0 || wb_valid)}, 32'd0);
    @(negedge clk);
  endtask

  task automatic dbg_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    int base;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; instr_valid = 1'b0; instr_op = 4'd0; instr_rd = 3'd0; instr_ra = 3'd0;
    instr_rb = 3'd0; instr_shamt = 5'd0; instr_imm = 32'd0; wb_ready = 1'b1; dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_err", {31'd0, err_illegal}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    dbg_check("rst_dbg_r3", 3'd3, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);

    // 1: back-to-back LDI, LDI, ADD with forwarding
    base = pop_cyc.size();
    issue(4'd11, 3'd1, 3'd0, 3'd0, 5'd0, 32'd19, 1'b1, 32'd19);
    issue(4'd11, 3'd2, 3'd0, 3'd0, 5'd0, 32'd55, 1'b1, 32'd55);
    issue(4'd0,  3'd3, 3'd1, 3'd2, 5'd0, 32'd0,  1'b1, 32'd74);
    drain();
    if (pop_cyc.size() >= base + 3) begin
      check("t1_consec_0", pop_cyc[base+1] - pop_cyc[base], 32'd1);
      check("t1_consec_1", pop_cyc[base+2] - pop_cyc[base+1], 32'd1);
    end else begin
      check("t1_records", pop_cyc.size() - base, 32'd3);
    end
    dbg_check("t1_dbg_r3", 3'd3, 32'd74);

    // 2: SUB and SLT both orders
    issue(4'd1, 3'd4, 3'd1, 3'd2, 5'd0, 32'd0, 1'b1, 32'hFFFFFFDC);
    check("t2_sub_class", {30'd0, alu_function_class}, 32'd2);
    check("t2_sub_c0", {31'd0, alu_c_0}, 32'd1);
    issue(4'd2, 3'd5, 3'd1, 3'd2, 5'd0, 32'd0, 1'b1, 32'd1);
    check("t2_slt_class", {30'd0, alu_function_class}, 32'd1);
    check("t2_slt_c0", {31'd0, alu_c_0}, 32'd1);
    issue(4'd2, 3'd5, 3'd2, 3'd1, 5'd0, 32'd0, 1'b1, 32'd0);
    drain();

    // 3: variable and constant shifts
    issue(4'd11, 3'd6, 3'd0, 3'd0, 5'd0, 32'd456, 1'b1, 32'd456);
    issue(4'd11, 3'd7, 3'd0, 3'd0, 5'd0, 32'd7,   1'b1, 32'd7);
    issue(4'd10, 3'd3, 3'd7, 3'd6, 5'd0, 32'd0,   1'b1, 32'd3);
    check("t3_srlv_cv", {31'd0, alu_const_var}, 32'd1);
    check("t3_srlv_dir", {31'd0, alu_shift_direction}, 32'd0);
    issue(4'd7, 3'd4, 3'd0, 3'd2, 5'd3, 32'd0, 1'b1, 32'd440);
    check("t3_sll_cv", {31'd0, alu_const_var}, 32'd0);
    check("t3_sll_dir", {31'd0, alu_shift_direction}, 32'd1);
    check("t3_sll_amt", {27'd0, alu_const_amount}, 32'd3);
    drain();
    dbg_check("t3_dbg_r3", 3'd3, 32'd3);

    // 4: backpressure fills EX and stalls issue; nothing lost on release
    wb_ready = 1'b0;
    issue(4'd5, 3'd5, 3'd1, 3'd2, 5'd0, 32'd0, 1'b1, 32'd36);
    issue(4'd4, 3'd6, 3'd1, 3'd2, 5'd0, 32'd0, 1'b1, 32'd55);
    instr_op = 4'd6; instr_rd = 3'd7; instr_ra = 3'd1; instr_rb = 3'd2; instr_valid = 1'b1;
    exp_q.push_back({3'd7, 32'hFFFFFFC8});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("t4_stall_ready", {31'd0, instr_ready}, 32'd0);
      check("t4_hold_valid", {31'd0, wb_valid}, 32'd1);
      check("t4_hold_rd", {29'd0, wb_rd}, 32'd5);
      check("t4_hold_data", wb_data, 32'd36);
    end
    @(negedge clk);
    wb_ready = 1'b1;
    wait_accept();
    drain();
    dbg_check("t4_dbg_r7", 3'd7, 32'hFFFFFFC8);

    // 5: illegal opcode, then a write to r0
    issue(4'd13, 3'd4, 3'd1, 3'd2, 5'd0, 32'd0, 1'b0, 32'd0);
    check("t5_err_set", {31'd0, err_illegal}, 32'd1);
    issue(4'd0, 3'd0, 3'd1, 3'd2, 5'd0, 32'd0, 1'b1, 32'd74);
    drain();
    check("t5_err_sticky", {31'd0, err_illegal}, 32'd1);
    dbg_check("t5_dbg_r0", 3'd0, 32'd0);
    dbg_check("t5_dbg_r4", 3'd4, 32'd440);

    // 6: asynchronous reset with EX and wb full
    wb_ready = 1'b0;
    issue(4'd5, 3'd5, 3'd1, 3'd2, 5'd0, 32'd0, 1'b0, 32'd0);
    issue(4'd4, 3'd6, 3'd1, 3'd2, 5'd0, 32'd0, 1'b0, 32'd0);
    check("t6_pre_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("t6_pre_class", {30'd0, alu_function_class}, 32'd3);
    #3;
    reset = 1'b1;
    #1;
    check("t6_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("t6_err", {31'd0, err_illegal}, 32'd0);
    check("t6_alu_a", alu_a, 32'd0);
    check("t6_alu_b", alu_b, 32'd0);
    check("t6_alu_ctl", {24'd0, alu_c_0, alu_const_var, alu_shift_direction,
                         alu_function_class, alu_logic_function, 1'b0}, 32'd0);
    check("t6_alu_amt", {27'd0, alu_const_amount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wb_ready = 1'b1;
    #1;
    check("t6_instr_ready", {31'd0, instr_ready}, 32'd1);
    for (int r = 0; r < 8; r++) begin
      dbg_check("t6_dbg_zero", r[2:0], 32'd0);
    end
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
